multdiv_sequencer: RTL and testbench

Control sequencer for the iterative multiply/divide unit in the multicycle MIPS datapath.
- Accepts a one-cycle start command from the main control FSM.
- Clears the unit, drives its operation-select for the exact iteration count, then pulses done and the Hi/Lo write enable.
- Raises a divide-by-zero exception and aborts cleanly.
- Stalls MFHI/MFLO while an operation is in flight.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_iter_counter.sv | 28 ++
 rtl/multdiv_sequencer.sv | 104 ++++++++++
 tb/tb_multdiv_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit, its sequencer and the main control FSM.
// Op encodings match the DivMultControl field the unit decodes.
package mdu_pkg;

  localparam logic [1:0] MDU_OP_HOLD = 2'b00;
  localparam logic [1:0] MDU_OP_MULT = 2'b01;
  localparam logic [1:0] MDU_OP_DIV  = 2'b10;

  localparam int MDU_MULT_CYCLES = 32;
  localparam int MDU_DIV_CYCLES  = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FINISH,
    ST_ABORT
  } mdu_state_e;

  function automatic logic mdu_op_valid(input logic [1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_counter.sv
// Iteration counter for the multiply/divide sequencer.
// terminal flags the last counted cycle so the sequencer can leave RUN on that edge.
module mdu_iter_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] last,
  output logic             terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable && (count == last);

endmodule

// File: rtl/multdiv_sequencer.sv
// Control sequencer for the iterative multiply/divide unit of the multicycle MIPS datapath.
// Clears the unit, runs it for the op's iteration count, then commits HI/LO or aborts on divide-by-zero.
module multdiv_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       hilo_rd,
  input  logic       mdu_divzero,
  output logic [1:0] mdu_ctrl,
  output logic       mdu_reset,
  output logic       busy,
  output logic       stall,
  output logic       hilo_we,
  output logic       done,
  output logic       div_zero_exc
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  logic [1:0]       op_q;
  logic             accept;
  logic             terminal;
  logic [CNT_W-1:0] last;

  // A start is only honoured from IDLE; anything else is dropped, never queued.
  assign accept = (state_q == ST_IDLE) && start && mdu_op_valid(op);
  assign last   = (op_q == MDU_OP_DIV) ? DIV_LAST : MULT_LAST;

  mdu_iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == ST_CLEAR),
    .enable   (state_q == ST_RUN),
    .last     (last),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_OP_HOLD;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= op;
      end
    end
  end

  // Divide-by-zero wins over the terminal count so a faulty divide never commits HI/LO.
  always_comb begin
    state_d      = state_q;
    mdu_ctrl     = MDU_OP_HOLD;
    mdu_reset    = reset;
    busy         = (state_q != ST_IDLE);
    hilo_we      = 1'b0;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        mdu_reset = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        mdu_ctrl = op_q;
        if ((op_q == MDU_OP_DIV) && mdu_divzero) begin
          state_d = ST_ABORT;
        end else if (terminal) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        hilo_we = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        mdu_reset    = 1'b1;
        div_zero_exc = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stall = hilo_rd & busy;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed timelines plus a completion scoreboard.
module tb_multdiv_sequencer;
  import mdu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       hilo_rd = 1'b0;
  logic       mdu_divzero = 1'b0;
  logic [1:0] mdu_ctrl;
  logic       mdu_reset;
  logic       busy;
  logic       stall;
  logic       hilo_we;
  logic       done;
  logic       div_zero_exc;

  typedef struct {
    bit is_exc;
    int cycle;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   s;

  multdiv_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .hilo_rd      (hilo_rd),
    .mdu_divzero  (mdu_divzero),
    .mdu_ctrl     (mdu_ctrl),
    .mdu_reset    (mdu_reset),
    .busy         (busy),
    .stall        (stall),
    .hilo_we      (hilo_we),
    .done         (done),
    .div_zero_exc (div_zero_exc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] o, input logic rd, input logic dz);
    start       = st;
    op          = o;
    hilo_rd     = rd;
    mdu_divzero = dz;
    #1;
  endtask

  // Expected outputs k cycles after an accepted start of an n-iteration op.
  task automatic checkTimeline(input logic [1:0] op_e, input int n, input int k, input logic rd);
    logic busy_e;
    logic fin_e;
    logic [1:0] ctrl_e;
    busy_e = (k >= 1) && (k <= n + 2);
    fin_e  = (k == n + 2);
    ctrl_e = ((k >= 2) && (k <= n + 1)) ? op_e : 2'b00;
    checkOutput("busy", busy, busy_e);
    checkOutput("mdu_reset", mdu_reset, k == 1);
    checkOutput("mdu_ctrl", mdu_ctrl, ctrl_e);
    checkOutput("done", done, fin_e);
    checkOutput("hilo_we", hilo_we, fin_e);
    checkOutput("div_zero_exc", div_zero_exc, 1'b0);
    checkOutput("stall", stall, rd & busy_e);
  endtask

  // Completion monitor: every done/exception pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done || div_zero_exc) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_kind_exc", div_zero_exc, e.is_exc);
        checkOutput("sb_cycle", cyc, e.cycle);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state, with hilo_rd high to show no stall.
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("rst_mdu_reset", mdu_reset, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ctrl", mdu_ctrl, 2'b00);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_hilo_we", hilo_we, 1'b0);
    checkOutput("rst_exc", div_zero_exc, 1'b0);
    checkOutput("rst_stall", stall, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("idle_mdu_reset", mdu_reset, 1'b0);

    // MULT with hilo_rd 5..40, stray DIV start at 10, divzero noise, start in FINISH.
    $display("[TB] MULT with ignored starts and MFHI stall");
    applyStimulus(1'b1, MDU_OP_MULT, 1'b0, 1'b0);
    s = cyc;
    sb.push_back('{is_exc: 1'b0, cycle: s + MDU_MULT_CYCLES + 2});
    checkTimeline(MDU_OP_MULT, MDU_MULT_CYCLES, 0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      applyStimulus((k == 10) || (k == 34), (k == 10) ? MDU_OP_DIV : MDU_OP_MULT,
                    (k >= 5) && (k <= 40), (k >= 3) && (k <= 6));
      checkTimeline(MDU_OP_MULT, MDU_MULT_CYCLES, k, (k >= 5) && (k <= 40));
    end
    tick();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("invalid_op_busy", busy, 1'b0);
    checkOutput("invalid_op_reset", mdu_reset, 1'b0);
    tick();

    // Plain DIV.
    $display("[TB] DIV normal");
    applyStimulus(1'b1, MDU_OP_DIV, 1'b0, 1'b0);
    s = cyc;
    sb.push_back('{is_exc: 1'b0, cycle: s + MDU_DIV_CYCLES + 2});
    for (int k = 1; k <= 37; k++) begin
      tick();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkTimeline(MDU_OP_DIV, MDU_DIV_CYCLES, k, 1'b0);
    end

    // DIV by zero flagged in the first RUN cycle.
    $display("[TB] DIV by zero");
    applyStimulus(1'b1, MDU_OP_DIV, 1'b0, 1'b0);
    s = cyc;
    sb.push_back('{is_exc: 1'b1, cycle: s + 3});
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkTimeline(MDU_OP_DIV, MDU_DIV_CYCLES, 1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("dz_run_ctrl", mdu_ctrl, MDU_OP_DIV);
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("dz_exc", div_zero_exc, 1'b1);
    checkOutput("dz_mdu_reset", mdu_reset, 1'b1);
    checkOutput("dz_hilo_we", hilo_we, 1'b0);
    checkOutput("dz_done", done, 1'b0);
    checkOutput("dz_ctrl", mdu_ctrl, 2'b00);
    checkOutput("dz_busy", busy, 1'b1);
    tick();
    checkOutput("dz_after_busy", busy, 1'b0);
    checkOutput("dz_after_exc", div_zero_exc, 1'b0);
    checkOutput("dz_after_reset", mdu_reset, 1'b0);

    // Reset in the middle of a DIV, then a fresh MULT.
    $display("[TB] reset during DIV");
    applyStimulus(1'b1, MDU_OP_DIV, 1'b0, 1'b0);
    s = cyc;
    for (int k = 1; k <= 19; k++) begin
      tick();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkTimeline(MDU_OP_DIV, MDU_DIV_CYCLES, k, 1'b0);
    end
    tick();
    reset = 1'b1;
    #1;
    checkOutput("midrst_mdu_reset", mdu_reset, 1'b1);
    checkOutput("midrst_done", done, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_ctrl", mdu_ctrl, 2'b00);
    checkOutput("midrst_hilo_we", hilo_we, 1'b0);
    checkOutput("midrst_exc", div_zero_exc, 1'b0);
    checkOutput("midrst_mdu_reset_low", mdu_reset, 1'b0);
    tick();
    applyStimulus(1'b1, MDU_OP_MULT, 1'b0, 1'b0);
    checkOutput("restart_cycle", cyc - s, 22);
    sb.push_back('{is_exc: 1'b0, cycle: s + 56});
    for (int k = 1; k <= 36; k++) begin
      tick();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkTimeline(MDU_OP_MULT, MDU_MULT_CYCLES, k, 1'b0);
    end

    tick();
    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
